// File: rtl/axil_router_rd.sv
// axil_router_rd: single-master AXI4-Lite read router behind an address decoder.
// Optional slave watchdog (SLVERR on expiry): define AXIL_ROUTER_RD_TIMEOUT_EN.
module axil_router_rd #(
   parameter int NUMBER_SLAVE   = 4,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int DEC_LATENCY    = 2,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                   aclk,
   input  logic                                   aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0]              m_axil_araddr,
   input  logic                                   m_axil_arvalid,
   output logic                                   m_axil_arready,
   output logic [AXI_DATA_WIDTH-1:0]              m_axil_rdata,
   output logic [1:0]                             m_axil_rresp,
   output logic                                   m_axil_rvalid,
   input  logic                                   m_axil_rready,
   output logic [AXI_ADDR_WIDTH-1:0]              dec_addr,
   output logic                                   dec_arvalid,
   input  logic [NUMBER_SLAVE-1:0]                dec_slv_valid,
   input  logic                                   dec_slv_invalid,
   output logic [NUMBER_SLAVE*AXI_ADDR_WIDTH-1:0] s_axil_araddr,
   output logic [NUMBER_SLAVE-1:0]                s_axil_arvalid,
   input  logic [NUMBER_SLAVE-1:0]                s_axil_arready,
   input  logic [NUMBER_SLAVE*AXI_DATA_WIDTH-1:0] s_axil_rdata,
   input  logic [NUMBER_SLAVE*2-1:0]              s_axil_rresp,
   input  logic [NUMBER_SLAVE-1:0]                s_axil_rvalid,
   output logic [NUMBER_SLAVE-1:0]                s_axil_rready
);

   localparam int AW = AXI_ADDR_WIDTH;
   localparam int DW = AXI_DATA_WIDTH;
   localparam int NS = NUMBER_SLAVE;
   localparam int SW = (NS > 1) ? $clog2(NS) : 1;
   localparam int CW = (DEC_LATENCY > 1) ? $clog2(DEC_LATENCY) : 1;

   if (DEC_LATENCY < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
      $error("axil_router_rd: DEC_LATENCY and TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [2:0] {
      IDLE, DECODE, AR_FWD, R_WAIT, R_ERR
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [CW-1:0] dec_cnt_q, dec_cnt_d;
   logic          live_q;
   logic [SW-1:0] hit_idx;
   logic          hit_any;
   logic          ar_hs, s_ar_hs, r_hs, dec_done;
   logic [1:0]    err_resp;

`ifdef AXIL_ROUTER_RD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          slverr_q, slverr_d, tmo_hit;
   assign tmo_hit  = (state_q == AR_FWD || state_q == R_WAIT)
                     && tmo_q == TW'(TIMEOUT_CYCLES - 1);
   assign err_resp = slverr_q ? 2'b10 : 2'b11;
`else
   assign err_resp = 2'b11;
`endif

   // arready is held off until the first edge after reset release
   assign ar_hs    = (state_q == IDLE) && live_q && m_axil_arvalid;
   assign s_ar_hs  = (state_q == AR_FWD) && s_axil_arready[sel_q];
   assign r_hs     = (state_q == R_WAIT) && s_axil_rvalid[sel_q]
                     && m_axil_rready;
   assign dec_done = dec_cnt_q == CW'(DEC_LATENCY - 1);

   always_comb begin
      hit_idx = '0;
      hit_any = 1'b0;
      for (int i = NS - 1; i >= 0; i--) begin
         if (dec_slv_valid[i]) begin
            hit_idx = SW'(i);
            hit_any = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         sel_q     <= '0;
         dec_cnt_q <= '0;
         live_q    <= 1'b0;
`ifdef AXIL_ROUTER_RD_TIMEOUT_EN
         tmo_q     <= '0;
         slverr_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         sel_q     <= sel_d;
         dec_cnt_q <= dec_cnt_d;
         live_q    <= 1'b1;
`ifdef AXIL_ROUTER_RD_TIMEOUT_EN
         tmo_q     <= tmo_d;
         slverr_q  <= slverr_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      sel_d     = sel_q;
      dec_cnt_d = dec_cnt_q;
`ifdef AXIL_ROUTER_RD_TIMEOUT_EN
      tmo_d     = '0;
      slverr_d  = slverr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (ar_hs) begin
               addr_d    = m_axil_araddr;
               dec_cnt_d = '0;
               state_d   = DECODE;
            end
         end
         DECODE: begin
            dec_cnt_d = dec_cnt_q + 1'b1;
            if (dec_done) begin
               if (dec_slv_invalid || !hit_any) begin
                  state_d = R_ERR;
               end else begin
                  sel_d   = hit_idx;
                  state_d = AR_FWD;
               end
            end
         end
         AR_FWD: if (s_ar_hs) state_d = R_WAIT;
         R_WAIT: if (r_hs) state_d = IDLE;
         R_ERR:  if (m_axil_rready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef AXIL_ROUTER_RD_TIMEOUT_EN
      if (ar_hs) slverr_d = 1'b0;
      if (state_q == AR_FWD || state_q == R_WAIT) begin
         tmo_d = tmo_q + 1'b1;
      end
      if (tmo_hit && !s_ar_hs && !r_hs) begin
         state_d  = R_ERR;
         slverr_d = 1'b1;
      end
`endif
   end

   always_comb begin
      m_axil_arready = 1'b0;
      m_axil_rvalid  = 1'b0;
      m_axil_rdata   = '0;
      m_axil_rresp   = '0;
      dec_addr       = addr_q;
      dec_arvalid    = 1'b0;
      s_axil_araddr  = '0;
      s_axil_arvalid = '0;
      s_axil_rready  = '0;
      unique case (state_q)
         IDLE:   m_axil_arready = live_q;
         DECODE: dec_arvalid = 1'b1;
         AR_FWD: begin
            s_axil_arvalid[sel_q] = 1'b1;
            s_axil_araddr[int'(sel_q)*AW +: AW] = addr_q;
         end
         R_WAIT: begin
            m_axil_rvalid = s_axil_rvalid[sel_q];
            m_axil_rdata  = s_axil_rdata[int'(sel_q)*DW +: DW];
            m_axil_rresp  = s_axil_rresp[int'(sel_q)*2 +: 2];
            s_axil_rready[sel_q] = m_axil_rready;
         end
         R_ERR: begin
            m_axil_rvalid = 1'b1;
            m_axil_rresp  = err_resp;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axil_router_rd.sv
// tb_axil_router_rd: vector table, corner sequences and random reads
// against a reference of the router's selection and response rules.
module tb_axil_router_rd;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  m_araddr = '0;
   logic         m_arvalid = 1'b0;
   logic         m_arready;
   logic [31:0]  m_rdata;
   logic [1:0]   m_rresp;
   logic         m_rvalid;
   logic         m_rready = 1'b0;
   logic [31:0]  dec_addr;
   logic         dec_arvalid;
   logic [3:0]   dv;
   logic         di;
   logic [127:0] s_araddr;
   logic [3:0]   s_arvalid;
   logic [3:0]   s_arready = '0;
   logic [127:0] s_rdata = '0;
   logic [7:0]   s_rresp = '0;
   logic [3:0]   s_rvalid = '0;
   logic [3:0]   s_rready;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axil_router_rd dut (
      .aclk            (clk),
      .aresetn         (rst_n),
      .m_axil_araddr   (m_araddr),
      .m_axil_arvalid  (m_arvalid),
      .m_axil_arready  (m_arready),
      .m_axil_rdata    (m_rdata),
      .m_axil_rresp    (m_rresp),
      .m_axil_rvalid   (m_rvalid),
      .m_axil_rready   (m_rready),
      .dec_addr        (dec_addr),
      .dec_arvalid     (dec_arvalid),
      .dec_slv_valid   (dv),
      .dec_slv_invalid (di),
      .s_axil_araddr   (s_araddr),
      .s_axil_arvalid  (s_arvalid),
      .s_axil_arready  (s_arready),
      .s_axil_rdata    (s_rdata),
      .s_axil_rresp    (s_rresp),
      .s_axil_rvalid   (s_rvalid),
      .s_axil_rready   (s_rready)
   );

   // address map: bit15 -> no-hit; bit14 -> multi-hit mask in [11:8];
   // otherwise slave [5:4]
   function automatic logic [3:0] dmask(input logic [31:0] a);
      if (a[14]) return a[11:8];
      return 4'(1 << a[5:4]);
   endfunction

   // decoder stand-in with one register stage: valid 2 cycles after drive
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv <= '0;
         di <= 1'b0;
      end else if (dec_arvalid) begin
         dv <= a15_mask(dec_addr);
         di <= dec_addr[15];
      end else begin
         dv <= '0;
         di <= 1'b0;
      end
   end

   function automatic logic [3:0] a15_mask(input logic [31:0] a);
      return a[15] ? 4'b0 : dmask(a);
   endfunction

   function automatic int ref_sel(input logic [31:0] a);
      logic [3:0] m;
      m = dmask(a);
      if (a[15] || m == 4'b0) return -1;
      for (int k = 0; k < 4; k++) if (m[k]) return k;
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [31:0] a, input int ard,
                          input int rd, input int mrd,
                          input logic [31:0] sd, input logic [1:0] sr,
                          input int esel, input logic [31:0] erd,
                          input logic [1:0] err, input bit now);
      int n;
      logic [3:0] oh;
      oh = (esel >= 0) ? 4'(1 << esel) : 4'b0;
      m_araddr  = a;
      m_arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!m_arready && n < 20) begin
         step();
         n++;
         @(negedge clk);
      end
      chk("ar_accept", m_arready, 1);
      if (now) chk("ar_b2b_wait", n, 0);
      step();
      m_arvalid = 1'b0;
      m_araddr  = $urandom;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         chk("dec_arvalid", dec_arvalid, 1);
         chk("dec_addr", dec_addr, a);
         chk("early_out", {m_rvalid, s_arvalid}, 0);
         step();
      end
      if (esel < 0) begin
         for (int c = 0; c <= mrd; c++) begin
            m_rready = (c == mrd);
            @(negedge clk);
            chk("err_rvalid", m_rvalid, 1);
            chk("err_rresp", m_rresp, err);
            chk("err_rdata", m_rdata, erd);
            chk("err_no_ar", s_arvalid, 0);
            step();
         end
         m_rready = 1'b0;
      end else begin
         for (int c = 0; c <= ard; c++) begin
            s_arready = 4'($urandom) & ~oh;
            if (c == ard) s_arready |= oh;
            @(negedge clk);
            chk("s_arvalid", s_arvalid, oh);
            chk("s_araddr", s_araddr[esel*32 +: 32], a);
            chk("rvalid_in_ar", m_rvalid, 0);
            step();
         end
         s_arready = '0;
         for (int c = 0; c < rd; c++) begin
            @(negedge clk);
            chk("r_wait_idle", {m_rvalid, s_arvalid}, 0);
            step();
         end
         s_rvalid = oh;
         s_rdata  = {$urandom, $urandom, $urandom, $urandom};
         s_rdata[esel*32 +: 32] = sd;
         s_rresp  = 8'($urandom);
         s_rresp[esel*2 +: 2] = sr;
         for (int c = 0; c <= mrd; c++) begin
            m_rready = (c == mrd);
            @(negedge clk);
            chk("m_rvalid", m_rvalid, 1);
            chk("m_rdata", m_rdata, erd);
            chk("m_rresp", m_rresp, err);
            chk("s_rready", s_rready, (c == mrd) ? oh : 4'b0);
            chk("ar_once", s_arvalid, 0);
            step();
         end
         m_rready = 1'b0;
         s_rvalid = '0;
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      int          ard;
      int          rd;
      int          mrd;
      logic [31:0] sdata;
      logic [1:0]  sresp;
      int          esel;
      logic [31:0] erdata;
      logic [1:0]  erresp;
   } vec_t;

   vec_t tv[9];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, sd;
      logic [1:0]  sr;
      int          es;

      tv[0] = '{32'h0000_0010, 0, 0, 0, 32'hDEAD_BEEF, 2'b00,
                1, 32'hDEAD_BEEF, 2'b00};
      tv[1] = '{32'h0000_8000, 0, 0, 2, 32'h1111_1111, 2'b00,
                -1, 32'h0, 2'b11};
      tv[2] = '{32'h0000_0020, 5, 1, 4, 32'h1234_5678, 2'b00,
                2, 32'h1234_5678, 2'b00};
      tv[3] = '{32'h0000_0000, 0, 0, 0, 32'hA5A5_0000, 2'b10,
                0, 32'hA5A5_0000, 2'b10};
      tv[4] = '{32'h0000_0030, 0, 0, 0, 32'h3333_CCCC, 2'b01,
                3, 32'h3333_CCCC, 2'b01};
      tv[5] = '{32'h0000_4A00, 1, 2, 1, 32'hCAFE_F00D, 2'b00,
                1, 32'hCAFE_F00D, 2'b00};
      tv[6] = '{32'h0000_4000, 0, 0, 0, 32'h7777_7777, 2'b00,
                -1, 32'h0, 2'b11};
      tv[7] = '{32'h0000_4F00, 2, 0, 0, 32'h0F0F_0F0F, 2'b11,
                0, 32'h0F0F_0F0F, 2'b11};
      tv[8] = '{32'h0000_4C30, 0, 3, 0, 32'hBEEF_0002, 2'b00,
                2, 32'hBEEF_0002, 2'b00};

      #1;
      chk("rst_outs", {m_arready, m_rvalid, dec_arvalid, |m_rdata,
                       |m_rresp, |dec_addr, |s_arvalid, |s_rready,
                       |s_araddr}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("arready_pre_edge", m_arready, 0);
      step();
      @(negedge clk);
      chk("arready_post_edge", m_arready, 1);
      step();

      foreach (tv[i])
         do_read(tv[i].addr, tv[i].ard, tv[i].rd, tv[i].mrd,
                 tv[i].sdata, tv[i].sresp, tv[i].esel,
                 tv[i].erdata, tv[i].erresp, 1'b1);

      // reset pulsed while a slave response is pending
      m_araddr  = 32'h0000_0020;
      m_arvalid = 1'b1;
      @(negedge clk);
      chk("rst_seq_accept", m_arready, 1);
      step();
      m_arvalid = 1'b0;
      step();
      step();
      s_arready = 4'b0100;
      @(negedge clk);
      chk("rst_seq_arvalid", s_arvalid, 4'b0100);
      step();
      s_arready = '0;
      s_rvalid  = 4'b0100;
      s_rdata[64 +: 32] = 32'h5555_AAAA;
      m_rready  = 1'b0;
      @(negedge clk);
      chk("rst_seq_rvalid", m_rvalid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_outs", {m_arready, m_rvalid, dec_arvalid, |m_rdata,
                             |m_rresp, |dec_addr, |s_arvalid, |s_rready,
                             |s_araddr}, 0);
      s_rvalid = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_arready_low", m_arready, 0);
      step();
      do_read(32'h0000_0030, 1, 1, 1, 32'h9999_0001, 2'b00,
              3, 32'h9999_0001, 2'b00, 1'b0);

      for (int it = 0; it < 40; it++) begin
         a      = $urandom;
         a[15]  = ($urandom_range(0, 4) == 0);
         a[14]  = 1'($urandom_range(0, 1));
         sd     = $urandom;
         sr     = 2'($urandom_range(0, 3));
         es     = ref_sel(a);
         do_read(a, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), sd, sr, es,
                 (es < 0) ? 32'h0 : sd, (es < 0) ? 2'b11 : sr, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
